// File: rtl/alu_pkg.sv
// Shared definitions for the ALU register bank and its load/execute sequencer.
package alu_pkg;

    localparam int STATE_W  = 3;
    localparam int RESULT_W = 9;

    typedef enum logic [STATE_W-1:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Board-side button/clear inputs and register-bank enables of the ALU sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic               next;
    logic               clear;
    logic               en_a;
    logic               en_b;
    logic               en_op;
    logic               en_result;
    logic [STATE_W-1:0] state_code;
    logic               busy;
    logic               done;

    modport master (
        output next, clear,
        input  en_a, en_b, en_op, en_result, state_code, busy, done
    );

    modport slave (
        input  next, clear,
        output en_a, en_b, en_op, en_result, state_code, busy, done
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Synchronizes the asynchronous push-button and emits a one-cycle rising-edge strobe.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Preset to 1 so a button held through reset release is not seen as a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/alu_sequencer.sv
// Steps the ALU register bank through load A / load B / load opcode / execute / show
// on successive button presses, with a programmable execute wait.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    localparam int              CNT_W    = $clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    logic press;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (bus.next),
        .edge_o (press)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_a_q, en_b_q, en_op_q, en_result_q;
    logic             busy_q, done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_A;
            cnt_q       <= '0;
            en_a_q      <= 1'b0;
            en_b_q      <= 1'b0;
            en_op_q     <= 1'b0;
            en_result_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            en_a_q      <= 1'b0;
            en_b_q      <= 1'b0;
            en_op_q     <= 1'b0;
            en_result_q <= 1'b0;
            // clear outranks both a press and exec completion
            if (bus.clear) begin
                state_q <= WAIT_A;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_A: if (press) begin
                        en_a_q  <= 1'b1;
                        state_q <= WAIT_B;
                    end
                    WAIT_B: if (press) begin
                        en_b_q  <= 1'b1;
                        state_q <= WAIT_OP;
                    end
                    WAIT_OP: if (press) begin
                        en_op_q <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                    // presses during execution are dropped
                    EXEC: begin
                        if (cnt_q <= CNT_LAST) begin
                            en_result_q <= 1'b1;
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= SHOW;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    SHOW: if (press) begin
                        done_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                endcase
            end
        end
    end

    assign bus.en_a       = en_a_q;
    assign bus.en_b       = en_b_q;
    assign bus.en_op      = en_op_q;
    assign bus.en_result  = en_result_q;
    assign bus.state_code = state_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Two sequencers (EXEC_CYCLES 3 and 8) share one stimulus stream and are checked
// every cycle against a timestamp-based reference model, plus directed scenario checks.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int SYNC = 2;

    logic clock = 1'b0;
    logic reset;
    logic next_r, clear_r;

    always #5 clock = ~clock;

    alu_sequencer_if if3();
    alu_sequencer_if if8();

    assign if3.next  = next_r;
    assign if3.clear = clear_r;
    assign if8.next  = next_r;
    assign if8.clear = clear_r;

    alu_sequencer #(.EXEC_CYCLES(3), .SYNC_STAGES(SYNC)) dut3 (
        .clock (clock), .reset (reset), .bus (if3.slave));
    alu_sequencer #(.EXEC_CYCLES(8), .SYNC_STAGES(SYNC)) dut8 (
        .clock (clock), .reset (reset), .bus (if8.slave));

    // {en_a, en_b, en_op, en_result, state_code[2:0], busy, done}
    logic [8:0] obs [2];
    assign obs[0] = {if3.en_a, if3.en_b, if3.en_op, if3.en_result, if3.state_code, if3.busy, if3.done};
    assign obs[1] = {if8.en_a, if8.en_b, if8.en_op, if8.en_result, if8.state_code, if8.busy, if8.done};

    int vectors = 0;
    int miscompares = 0;

    // reference model: button samples in a queue, exec timed by edge timestamps
    bit         q[$];
    int         cyc;
    int         m_st [2];
    int         m_t0 [2];
    logic [8:0] m_out [2];
    int         n_a [2], n_b [2], n_op [2], n_res [2];

    function automatic int exn(input int i);
        return (i == 0) ? 3 : 8;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k <= SYNC; k++) q.push_back(1'b1);
        for (int i = 0; i < 2; i++) begin
            m_st[i]  = 0;
            m_out[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit       e;
        bit [3:0] en;
        e = q[1] & ~q[0];
        q.push_back(next_r);
        void'(q.pop_front());
        cyc++;
        for (int i = 0; i < 2; i++) begin
            en = 4'b0000;
            if (clear_r) m_st[i] = 0;
            else begin
                case (m_st[i])
                    0: if (e) begin m_st[i] = 1; en = 4'b1000; end
                    1: if (e) begin m_st[i] = 2; en = 4'b0100; end
                    2: if (e) begin m_st[i] = 3; en = 4'b0010; m_t0[i] = cyc; end
                    3: if (cyc - m_t0[i] == exn(i)) begin m_st[i] = 4; en = 4'b0001; end
                    4: if (e) m_st[i] = 0;
                    default: m_st[i] = 0;
                endcase
            end
            m_out[i] = {en, 3'(m_st[i]), m_st[i] == 3, m_st[i] == 4};
        end
    endtask

    task automatic chk(input int i, input string tag, input logic [8:0] o, input logic [8:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %b expected %b", tag, i, o, e);
        end
    endtask

    task automatic chkv(input string tag, input int o, input int e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else model_edge();
        for (int i = 0; i < 2; i++) begin
            chk(i, "cycle", obs[i], m_out[i]);
            n_a[i]   += int'(obs[i][8]);
            n_b[i]   += int'(obs[i][7]);
            n_op[i]  += int'(obs[i][6]);
            n_res[i] += int'(obs[i][5]);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input int hi, input int lo);
        next_r = 1'b1;
        steps(hi);
        next_r = 1'b0;
        steps(lo);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(3);
    endtask

    // holds next high until the chosen instance pulses en_op
    task automatic wait_op(input int i);
        bit seen;
        seen   = 1'b0;
        next_r = 1'b1;
        for (int k = 0; k < 12 && !seen; k++) begin
            step();
            seen = obs[i][6];
        end
        chkv("en_op_seen", int'(seen), 1);
    endtask

    int r0, r1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            n_a[i] = 0; n_b[i] = 0; n_op[i] = 0; n_res[i] = 0; m_t0[i] = 0;
        end
        cyc     = 0;
        reset   = 1'b1;
        next_r  = 1'b0;
        clear_r = 1'b0;
        model_reset();
        #1;
        chk(0, "reset_state", obs[0], 9'b0);
        chk(1, "reset_state", obs[1], 9'b0);
        steps(2);
        reset = 1'b0;
        steps(4);

        // three presses load A, B, opcode; dut3 completes execution
        press(4, 4); press(4, 4); press(4, 4);
        steps(4);
        chkv("a_pulses",   n_a[0], 1);
        chkv("b_pulses",   n_b[0], 1);
        chkv("op_pulses",  n_op[0], 1);
        chkv("res_pulses", n_res[0], 1);
        chkv("show_code",  int'(obs[0][4:2]), 4);
        chkv("show_done",  int'(obs[0][0]), 1);
        chkv("res8_pulses", n_res[1], 1);

        // press in SHOW returns to WAIT_A with no load
        r0 = n_a[0] + n_b[0] + n_op[0] + n_res[0];
        press(4, 4);
        chkv("show_exit_nopulse", n_a[0] + n_b[0] + n_op[0] + n_res[0], r0);
        chkv("show_exit_code",    int'(obs[0][4:2]), 0);
        press(4, 4);
        chkv("a_after_show", n_a[0], 2);

        // presses during a long execute are dropped
        press(4, 4);
        r1 = n_res[1];
        wait_op(1);
        next_r = 1'b0; step(); next_r = 1'b1; step();
        next_r = 1'b0; step(); next_r = 1'b1; step();
        next_r = 1'b0; step(); next_r = 1'b1; step();
        next_r = 1'b0;
        steps(6);
        chkv("exec_res_once", n_res[1] - r1, 1);
        chkv("exec_ign_code", int'(obs[1][4:2]), 4);

        // clear on the completion edge suppresses en_result
        do_reset();
        press(4, 4); press(4, 4);
        wait_op(0);
        next_r = 1'b0;
        steps(2);
        r0 = n_res[0];
        clear_r = 1'b1;
        step();
        clear_r = 1'b0;
        chkv("clr_no_result", int'(obs[0][5]), 0);
        chkv("clr_code",      int'(obs[0][4:2]), 0);
        chkv("clr_busy",      int'(obs[0][1]), 0);
        steps(5);
        chkv("clr_no_late_res", n_res[0], r0);

        // asynchronous reset mid-execute
        do_reset();
        press(4, 4); press(4, 4);
        wait_op(1);
        next_r = 1'b0;
        steps(2);
        r1 = n_res[1];
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk(1, "async_reset", obs[1], m_out[1]);
        chkv("async_busy", int'(obs[1][1]), 0);
        chkv("async_code", int'(obs[1][4:2]), 0);
        steps(2);
        reset = 1'b0;
        steps(12);
        chkv("async_no_res", n_res[1], r1);

        // button held through reset release is not a press
        r0 = n_a[0];
        next_r = 1'b1;
        reset  = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(8);
        chkv("held_no_a", n_a[0], r0);
        next_r = 1'b0;
        steps(4);
        press(4, 4);
        chkv("held_then_a", n_a[0], r0 + 1);

        // randomized button / clear activity checked against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) next_r = ~next_r;
            clear_r = ($urandom_range(0, 15) == 0);
            step();
        end
        clear_r = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control FSM that steps the ALU through a user-driven load/execute/show cycle. It turns a single asynchronous "next" push-button into one-cycle load-enable pulses for the operand A, operand B, opcode and 9-bit result registers, in that order. After a programmable execute wait it captures the ALU result. It sits between the board inputs and the enable pins of the ALU register bank.

## Interface
Parameters:
- EXEC_CYCLES, 1, clock edges from the en_op pulse to the en_result pulse (legal ≥1)
- SYNC_STAGES, 2, flops in the next-button synchronizer (legal ≥2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clock clock
- next  in  1  user button, asynchronous level, active-high
- clear  in  1  synchronous abort to WAIT_A, active-high, assumed already synchronous to clock
- en_a  out  1  one-cycle load pulse for the operand A register
- en_b  out  1  one-cycle load pulse for the operand B register
- en_op  out  1  one-cycle load pulse for the opcode register
- en_result  out  1  one-cycle load pulse for the result register
- state_code  out  3  current state encoding, for LEDs
- busy  out  1  high while in EXEC
- done  out  1  high while in SHOW

## Operation
- States and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4. Codes 5–7 are unreachable; if entered, go to WAIT_A.
- An "edge" is: synchronized next = 1 while the previously sampled synchronized next = 0.
- WAIT_A + edge: pulse en_a, go to WAIT_B.
- WAIT_B + edge: pulse en_b, go to WAIT_OP.
- WAIT_OP + edge: pulse en_op, go to EXEC, load exec counter with EXEC_CYCLES.
- EXEC: decrement the counter every cycle. When it reaches the final count, pulse en_result and go to SHOW. Edges in EXEC are dropped, not queued.
- SHOW + edge: go to WAIT_A. No enable pulse is issued.
- clear has priority over edge and over exec completion. clear in any state: next state WAIT_A, all enables 0 that cycle.
- At most one en_* is high in any cycle. All outputs are registered.
- Reset: state WAIT_A, all en_* = 0, busy = 0, done = 0, state_code = 0, counter = 0.
- Reset presets the synchronizer flops and the edge-history flop to 1. A button held through reset release therefore produces no load until it is released and pressed again.

## Timing
- next rises before edge 1 (setup met): en_x is high from edge SYNC_STAGES+1 to edge SYNC_STAGES+2. state_code changes at edge SYNC_STAGES+1.
- en_result rises exactly EXEC_CYCLES edges after the edge at which en_op rises. state_code becomes 4 and done rises at the same edge.
- busy rises with en_op and falls with en_result.
- Minimum spacing between consecutive loads: one edge detection per press. A release of at least one cycle is required between presses.
- Reset asserted mid-EXEC: all outputs go to their reset values immediately (asynchronous). After release, the FSM sits in WAIT_A and en_result is never issued.
- clear on the same edge that exec completes: no en_result pulse, state goes to WAIT_A.

## Structure
- Shared package alu_pkg holds the state encodings, the state_code width (3) and the result width (9) used by the register bank.
- Sub-module btn_edge_sync: an SYNC_STAGES-flop synchronizer plus the edge-history flop, all preset to 1 on reset. It outputs a one-cycle combinational edge strobe.
- Top level holds the FSM, the exec counter and the output registers.

## Test plan
- Reset, then press next three times (each 4 cycles high, 4 low), SYNC_STAGES=2, EXEC_CYCLES=3 -> en_a, en_b, en_op each high exactly one cycle, 3 edges after each press. en_result high 3 edges after en_op. done=1, state_code=4.
- Hold next high through reset release -> no en_a. Release then press -> en_a once.
- Press next 3 times during EXEC (EXEC_CYCLES=8) -> presses ignored. Exactly one en_result. State SHOW, not WAIT_A.
- Assert clear on the exact edge en_result would fire -> en_result stays 0, state_code=0, busy=0.
- Assert async reset mid-EXEC between clock edges -> busy and state_code drop to 0 before the next edge. No en_result follows.
- In SHOW, press next -> state_code=0, no en_* pulse. Next press -> en_a.
